// File: rtl/med_reminder_ctrl.sv
// med_reminder_ctrl: medication alarm with hour/minute edit sessions, ring timeout and taken/missed dose counters.
module med_reminder_ctrl #(
  parameter int EDIT_TIMEOUT = 30000000,
  parameter int RING_CYCLES  = 60000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_next,
  input  logic       key_ok,
  input  logic       key_cancel,
  input  logic       key_ack,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic       min_tick,
  output logic [1:0] state,
  output logic [4:0] alm_hour,
  output logic [5:0] alm_min,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min,
  output logic       alarm_en,
  output logic       buzzer,
  output logic [7:0] taken_cnt,
  output logic [3:0] missed_cnt
);
  localparam int EW = EDIT_TIMEOUT > 1 ? $clog2(EDIT_TIMEOUT) : 1;
  localparam int RW = RING_CYCLES > 1 ? $clog2(RING_CYCLES) : 1;
  localparam logic [EW-1:0] ELAST = EW'(EDIT_TIMEOUT - 1);
  localparam logic [RW-1:0] RLAST = RW'(RING_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, RING} st_t;
  st_t st;
  logic [4:0] sh_h;
  logic [5:0] sh_m;
  logic [EW-1:0] ecnt;
  logic [RW-1:0] rcnt;
  logic any_key, match, editing;
  assign any_key = key_mode | key_up | key_down | key_next | key_ok | key_cancel | key_ack;
  assign match = alarm_en && min_tick && cur_hour == alm_hour && cur_min == alm_min;
  assign editing = st == EDIT_H || st == EDIT_M;
  assign state = st;
  assign disp_hour = editing ? sh_h : alm_hour;
  assign disp_min = editing ? sh_m : alm_min;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      alm_hour <= 5'd8;
      alm_min <= '0;
      sh_h <= 5'd8;
      sh_m <= '0;
      alarm_en <= 1'b0;
      buzzer <= 1'b0;
      taken_cnt <= '0;
      missed_cnt <= '0;
      ecnt <= '0;
      rcnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (match) begin
            st <= RING;
            buzzer <= 1'b1;
            rcnt <= '0;
          end else begin
            if (key_mode) begin
              st <= EDIT_H;
              sh_h <= alm_hour;
              sh_m <= alm_min;
              ecnt <= '0;
            end
            if (key_ok) alarm_en <= !alarm_en;
            if (key_cancel) missed_cnt <= '0;
          end
        end
        EDIT_H, EDIT_M: begin
          ecnt <= any_key ? '0 : ecnt + EW'(1);
          if (key_cancel || (!any_key && ecnt == ELAST)) st <= IDLE;
          else if (key_ok) begin
            alm_hour <= sh_h;
            alm_min <= sh_m;
            alarm_en <= 1'b1;
            st <= IDLE;
          end else if (key_next) st <= st == EDIT_H ? EDIT_M : EDIT_H;
          else if (key_up ^ key_down) begin
            if (st == EDIT_H) sh_h <= key_up ? (sh_h == 5'd23 ? 5'd0 : sh_h + 5'd1) : (sh_h == 5'd0 ? 5'd23 : sh_h - 5'd1);
            else sh_m <= key_up ? (sh_m == 6'd59 ? 6'd0 : sh_m + 6'd1) : (sh_m == 6'd0 ? 6'd59 : sh_m - 6'd1);
          end
        end
        RING: begin
          rcnt <= rcnt + RW'(1);
          if (key_ack) begin
            st <= IDLE;
            buzzer <= 1'b0;
            taken_cnt <= taken_cnt == 8'hff ? taken_cnt : taken_cnt + 8'd1;
          end else if (rcnt == RLAST) begin
            st <= IDLE;
            buzzer <= 1'b0;
            missed_cnt <= missed_cnt == 4'hf ? missed_cnt : missed_cnt + 4'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_med_reminder_ctrl.sv
// tb_med_reminder_ctrl: directed and random checks against a minutes-of-day reference model.
module tb_med_reminder_ctrl;
  localparam int ET = 8, RC = 16;
  logic clk = 0, rst_n = 0;
  logic key_mode = 0, key_up = 0, key_down = 0, key_next = 0, key_ok = 0, key_cancel = 0, key_ack = 0;
  logic [4:0] cur_hour = 0;
  logic [5:0] cur_min = 0;
  logic min_tick = 0;
  logic [1:0] state;
  logic [4:0] alm_hour, disp_hour;
  logic [5:0] alm_min, disp_min;
  logic alarm_en, buzzer;
  logic [7:0] taken_cnt;
  logic [3:0] missed_cnt;
  int errs = 0, checks = 0;
  int m_mode, m_alm, m_sh, m_en, m_taken, m_missed, m_idle, m_ring;

  med_reminder_ctrl #(.EDIT_TIMEOUT(ET), .RING_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .key_next(key_next), .key_ok(key_ok), .key_cancel(key_cancel), .key_ack(key_ack),
    .cur_hour(cur_hour), .cur_min(cur_min), .min_tick(min_tick), .state(state),
    .alm_hour(alm_hour), .alm_min(alm_min), .disp_hour(disp_hour), .disp_min(disp_min),
    .alarm_en(alarm_en), .buzzer(buzzer), .taken_cnt(taken_cnt), .missed_cnt(missed_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_mode = 0; m_alm = 480; m_sh = 480; m_en = 0; m_taken = 0; m_missed = 0; m_idle = 0; m_ring = 0;
  endtask

  // Reference: times held as minutes-of-day, edits done with modular arithmetic on that count.
  task automatic model_step();
    bit any;
    int h, m;
    any = key_mode | key_up | key_down | key_next | key_ok | key_cancel | key_ack;
    h = m_sh / 60; m = m_sh % 60;
    if (m_mode == 0) begin
      if (m_en != 0 && min_tick && int'(cur_hour) * 60 + int'(cur_min) == m_alm) begin
        m_mode = 3; m_ring = 0;
      end else begin
        if (key_mode) begin m_mode = 1; m_sh = m_alm; m_idle = 0; end
        if (key_ok) m_en = 1 - m_en;
        if (key_cancel) m_missed = 0;
      end
    end else if (m_mode == 3) begin
      if (key_ack) begin m_mode = 0; m_taken = m_taken < 255 ? m_taken + 1 : 255; end
      else if (m_ring == RC - 1) begin m_mode = 0; m_missed = m_missed < 15 ? m_missed + 1 : 15; end
      else m_ring++;
    end else begin
      if (key_cancel || (!any && m_idle == ET - 1)) m_mode = 0;
      else if (key_ok) begin m_alm = m_sh; m_en = 1; m_mode = 0; end
      else if (key_next) m_mode = 3 - m_mode;
      else if (key_up != key_down) begin
        if (m_mode == 1) m_sh = ((h + (key_up ? 1 : 23)) % 24) * 60 + m;
        else m_sh = h * 60 + (m + (key_up ? 1 : 59)) % 60;
      end
      m_idle = any ? 0 : m_idle + 1;
    end
  endtask

  task automatic check_all();
    int d;
    d = (m_mode == 1 || m_mode == 2) ? m_sh : m_alm;
    chk("state", state, m_mode);
    chk("alm_hour", alm_hour, m_alm / 60);
    chk("alm_min", alm_min, m_alm % 60);
    chk("disp_hour", disp_hour, d / 60);
    chk("disp_min", disp_min, d % 60);
    chk("alarm_en", alarm_en, m_en);
    chk("buzzer", buzzer, m_mode == 3);
    chk("taken_cnt", taken_cnt, m_taken);
    chk("missed_cnt", missed_cnt, m_missed);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    {key_ack, key_cancel, key_ok, key_next, key_down, key_up, key_mode} = '0;
    min_tick = 0;
    check_all();
  endtask

  // mask bits: 0 mode, 1 up, 2 down, 3 next, 4 ok, 5 cancel, 6 ack
  task automatic press(input logic [6:0] k);
    {key_ack, key_cancel, key_ok, key_next, key_down, key_up, key_mode} = k;
    step();
  endtask

  task automatic tick_at(input int hh, input int mm);
    cur_hour = 5'(hh); cur_min = 6'(mm); min_tick = 1;
    step();
  endtask

  initial begin
    mreset();
    #12;
    check_all();
    rst_n = 1;
    @(negedge clk);
    // edit 08:00 -> 11:59
    press(7'h01); chk("enter_edit_h", state, 1);
    repeat (3) press(7'h02);
    press(7'h08); chk("enter_edit_m", state, 2);
    press(7'h04);
    press(7'h10);
    chk("edit_alm_hour", alm_hour, 11); chk("edit_alm_min", alm_min, 59);
    chk("edit_alarm_en", alarm_en, 1); chk("edit_idle", state, 0);
    // wrap boundaries
    press(7'h01);
    repeat (12) press(7'h02);
    chk("hour_23", disp_hour, 23);
    press(7'h02); chk("hour_wrap", disp_hour, 0);
    press(7'h08); press(7'h02); chk("min_wrap_up", disp_min, 0);
    press(7'h04); chk("min_wrap_down", disp_min, 59);
    press(7'h06); chk("up_down_same", disp_min, 59);
    press(7'h20); chk("cancel_keeps", alm_hour, 11);
    // back to 08:00 and ring
    press(7'h01); repeat (3) press(7'h04); press(7'h08); press(7'h02); press(7'h10);
    chk("alm_0800", {alm_hour, alm_min}, {5'd8, 6'd0});
    tick_at(8, 0);
    chk("ring_state", state, 3); chk("ring_buzzer", buzzer, 1);
    press(7'h40); chk("ack_idle", state, 0); chk("ack_taken", taken_cnt, 1);
    // missed saturation
    for (int i = 0; i < 17; i++) begin
      tick_at(8, 0);
      repeat (RC - 1) step();
      chk("ring_held", state, 3);
      step();
      chk("ring_timeout", state, 0);
    end
    chk("missed_sat", missed_cnt, 15);
    press(7'h20); chk("missed_clear", missed_cnt, 0);
    // edit timeout
    press(7'h01); press(7'h02);
    repeat (ET - 1) step();
    chk("edit_hold", state, 1);
    step();
    chk("edit_timeout", state, 0); chk("timeout_alm", alm_hour, 8);
    // asynchronous reset mid-ring
    tick_at(8, 0);
    chk("pre_reset_ring", state, 3);
    #2 rst_n = 0;
    #1;
    mreset();
    chk("async_buzzer", buzzer, 0); chk("async_state", state, 0); chk("async_taken", taken_cnt, 0);
    check_all();
    @(negedge clk);
    rst_n = 1;
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7) {key_ack, key_cancel, key_ok, key_next, key_down, key_up, key_mode} = 7'(1 << r);
      else if (r == 7) {key_down, key_up} = 2'b11;
      if ($urandom_range(0, 3) == 0) begin
        min_tick = 1;
        if ($urandom_range(0, 1) == 0) begin cur_hour = 5'(m_alm / 60); cur_min = 6'(m_alm % 60); end
        else begin cur_hour = 5'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59)); end
      end
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/med_reminder_ctrl.md
MED_REMINDER_CTRL -- requirements
Module: med_reminder_ctrl

Interface
REQ-001 SHALL have parameter EDIT_TIMEOUT, default 30000000, clk cycles without a key pulse before an edit session is abandoned.
REQ-002 SHALL have parameter RING_CYCLES, default 60000000, clk cycles the buzzer sounds before the dose is logged as missed.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports key_mode, key_up, key_down, key_next, key_ok, key_cancel, key_ack  input  1 each  one-cycle key pulses synchronous to clk.
REQ-006 SHALL have port cur_hour  input  5  current hour, binary 0-23.
REQ-007 SHALL have port cur_min  input  6  current minute, binary 0-59.
REQ-008 SHALL have port min_tick  input  1  one-cycle pulse when cur_hour/cur_min take a new value.
REQ-009 SHALL have port state  output  2  0=IDLE, 1=EDIT_H, 2=EDIT_M, 3=RING.
REQ-010 SHALL have ports alm_hour  output  5 and alm_min  output  6  committed alarm time.
REQ-011 SHALL have ports disp_hour  output  5 and disp_min  output  6  shadow value in EDIT_H/EDIT_M, committed value otherwise.
REQ-012 SHALL have ports alarm_en  output  1, buzzer  output  1, taken_cnt  output  8, missed_cnt  output  4.

Function
REQ-013 IDLE: key_mode SHALL copy alm_hour/alm_min to shadow and enter EDIT_H next cycle.
REQ-014 IDLE: key_ok SHALL toggle alarm_en; key_cancel SHALL clear missed_cnt to 0.
REQ-015 EDIT_H: key_up SHALL increment shadow hour mod 24 (23->0); key_down SHALL decrement (0->23).
REQ-016 EDIT_M: key_up SHALL increment shadow minute mod 60 (59->0); key_down SHALL decrement (0->59).
REQ-017 key_up and key_down asserted in the same cycle SHALL leave the shadow unchanged.
REQ-018 key_next SHALL toggle EDIT_H <-> EDIT_M, shadow retained.
REQ-019 key_ok in either edit state SHALL write the shadow to alm_hour/alm_min, set alarm_en=1, and enter IDLE in one cycle.
REQ-020 key_cancel in either edit state SHALL enter IDLE, committed values unchanged.
REQ-021 Edit-state key priority SHALL be cancel > ok > next > up/down; key_mode and key_ack SHALL be ignored.
REQ-022 An edit-inactivity counter SHALL reset to 0 on any key pulse and on edit entry; on reaching EDIT_TIMEOUT-1 it SHALL force IDLE as if key_cancel.
REQ-023 IDLE with alarm_en=1, min_tick=1, cur_hour==alm_hour and cur_min==alm_min SHALL enter RING next cycle.
REQ-024 A match occurring in EDIT_H/EDIT_M or RING SHALL be ignored, with no missed_cnt change.
REQ-025 When a match and an IDLE key pulse occur in the same cycle, the match SHALL win and the key SHALL be ignored.
REQ-026 buzzer SHALL equal 1 exactly while state==RING (registered, no combinational path from inputs).
REQ-027 RING: key_ack SHALL enter IDLE and increment taken_cnt, saturating at 255.
REQ-028 A ring counter SHALL start at 0 on RING entry; on reaching RING_CYCLES-1 without key_ack, the block SHALL enter IDLE and increment missed_cnt, saturating at 15.
REQ-029 key_ack in the same cycle as ring timeout SHALL be counted as taken only.
REQ-030 RING SHALL ignore all keys other than key_ack.
REQ-031 Counter widths SHALL be $clog2 of their parameter, minimum 1.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, alm_hour=8, alm_min=0, shadow=08:00, alarm_en=0, buzzer=0, taken_cnt=0, missed_cnt=0, both timers=0.
REQ-033 Reset asserted during EDIT or RING SHALL discard the shadow and silence the buzzer without waiting for a clock edge.
REQ-034 After rst_n deasserts, the first rising edge SHALL process inputs normally.

Verification
REQ-035 mode, up x3, next, down x1, ok -> alm=11:59, alarm_en=1, state=IDLE.
REQ-036 In EDIT_H at 23, key_up -> disp_hour=0; in EDIT_M at 0, key_down -> disp_min=59; up+down together -> no change.
REQ-037 alm=08:00, alarm_en=1, min_tick with cur=08:00 -> state=RING and buzzer=1 next cycle; key_ack -> IDLE, taken_cnt=1.
REQ-038 With RING_CYCLES=16, no ack -> IDLE after 16 cycles, missed_cnt=1; repeat 16 times -> missed_cnt stays 15; key_cancel in IDLE -> 0.
REQ-039 With EDIT_TIMEOUT=8, mode, up, then 8 idle cycles -> IDLE, alm unchanged at 08:00.
REQ-040 Assert rst_n=0 mid-RING between clock edges -> buzzer=0 and state=IDLE asynchronously, with all counts 0.
